// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared constants for the instruction fetch path: datapath width, the
// canonical NOP (addi x0,x0,0), the sequential PC increment and the fetch
// FSM state encodings. Also provides the PC word-alignment helper.
// -----------------------------------------------------------------------------
package rv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Fetch FSM state encodings (kept as plain constants for legacy tools).
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_ISSUE = 2'd0;
  localparam fetch_state_t ST_WAIT  = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;

  // Clear the byte-offset bits so a PC always names a whole word.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// -----------------------------------------------------------------------------
// fetch_skid_reg
// One-entry instruction buffer (valid + word + PC). Used both as the IF/ID
// register and as the skid buffer that parks a returned word while decode
// is stalled. An empty entry presents NOP_INSTR on its data output.
//
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   flush                 invalidate the entry (highest priority)
//   load, load_data/pc    capture a new word (beats clear)
//   clear                 entry consumed downstream
//   valid, data, pc       registered contents
// -----------------------------------------------------------------------------
module fetch_skid_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [31:0] load_pc,
  input  logic        clear,
  output logic        valid,
  output logic [31:0] data,
  output logic [31:0] pc
);

  // Entry update: flush, then load, then clear; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= NOP_INSTR;
      pc    <= 32'h0000_0000;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      pc    <= load_pc;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: owns the PC, issues one word fetch at a time over
// a req/gnt/rvalid handshake, buffers returned words in the IF/ID register
// (with a one-entry skid for decode back-pressure) and handles redirects.
//
// Ports:
//   clk, rst_n                      clock / asynchronous active-low reset
//   imem_req, imem_addr             fetch request and word-aligned address
//   imem_gnt                        request accepted this cycle
//   imem_rvalid, imem_rdata         returned instruction word
//   redirect, redirect_pc           taken branch/jump pulse and target
//   id_ready                        decode consumes IF/ID this cycle
//   full_intruc, if_pc, if_valid    IF/ID contents presented to decode
//   fetch_misalign                  misaligned-target flag (FETCH_MISALIGN_EN)
//
// Build option: define FETCH_MISALIGN_EN to trap misaligned redirect targets
// instead of silently masking the low address bits.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic [31:0] full_intruc,
  output logic [31:0] if_pc,
`ifdef FETCH_MISALIGN_EN
  output logic        fetch_misalign,
`endif
  output logic        if_valid
);

  import rv_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic              started_q;
  logic              mis_q, mis_d;

  logic              if_flush, if_load, if_clear;
  logic [XLEN-1:0]   if_ld_data, if_ld_pc;
  logic              sk_flush, sk_load, sk_clear, sk_valid;
  logic [XLEN-1:0]   sk_data, sk_pc;

  logic              consume, can_take, mis_redirect, outstanding, returning;

  assign consume  = if_valid & id_ready;
  assign can_take = ~if_valid | id_ready;

  // started_q keeps the request low while reset is held and for the edge
  // that releases it; drop_q blocks a new request while a stale one is out.
  assign imem_req  = started_q & (state_q == ST_ISSUE) & ~drop_q;
  assign imem_addr = pc_q;

`ifdef FETCH_MISALIGN_EN
  assign mis_redirect   = redirect & (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = mis_q;
`else
  assign mis_redirect   = 1'b0;
`endif

  // A request is in flight if we are waiting on it, it is granted right now,
  // or an earlier cancelled one has not returned yet.
  assign outstanding = (state_q == ST_WAIT) | (imem_req & imem_gnt) | drop_q;
  assign returning   = imem_rvalid & ((state_q == ST_WAIT) | drop_q);

  // Next-state, PC and buffer-control decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    mis_d      = mis_q;
    if_flush   = 1'b0;
    if_load    = 1'b0;
    if_clear   = consume;
    if_ld_data = imem_rdata;
    if_ld_pc   = pc_q;
    sk_flush   = 1'b0;
    sk_load    = 1'b0;
    sk_clear   = 1'b0;

    if (redirect) begin
      // Redirect beats everything: both buffers are invalidated and any
      // response still to come for the old path is marked for discard.
      sk_flush = 1'b1;
      drop_d   = outstanding & ~returning;
      pc_d     = align_word(redirect_pc);
      mis_d    = mis_redirect;
      if (mis_redirect) begin
        if_load    = 1'b1;
        if_ld_data = NOP_INSTR;
        if_ld_pc   = redirect_pc;
        state_d    = ST_HOLD;
      end else begin
        if_flush = 1'b1;
        state_d  = ST_ISSUE;
      end
    end else begin
      if (drop_q && imem_rvalid) begin
        drop_d = 1'b0;
      end else begin
        drop_d = drop_q;
      end

      case (state_q)
        ST_ISSUE: begin
          if (imem_req && imem_gnt) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid && !drop_q) begin
            pc_d = pc_q + PC_STEP;
            if (can_take) begin
              if_load = 1'b1;
              state_d = ST_ISSUE;
            end else begin
              sk_load = 1'b1;
              state_d = ST_HOLD;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_HOLD: begin
          // A misaligned trap parks here until the next redirect.
          if (mis_q) begin
            state_d = ST_HOLD;
          end else if (can_take) begin
            if_load    = sk_valid;
            if_ld_data = sk_data;
            if_ld_pc   = sk_pc;
            sk_clear   = 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_ISSUE;
        end
      endcase
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ISSUE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      started_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      started_q <= 1'b1;
      mis_q     <= mis_d;
    end
  end

  fetch_skid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (if_flush),
    .load      (if_load),
    .load_data (if_ld_data),
    .load_pc   (if_ld_pc),
    .clear     (if_clear),
    .valid     (if_valid),
    .data      (full_intruc),
    .pc        (if_pc)
  );

  fetch_skid_reg #(.NOP_INSTR(NOP_INSTR)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (sk_flush),
    .load      (sk_load),
    .load_data (imem_rdata),
    .load_pc   (pc_q),
    .clear     (sk_clear),
    .valid     (sk_valid),
    .data      (sk_data),
    .pc        (sk_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. A small memory responder grants every
// request in the same cycle and returns the word rsp_delay cycles later.
// Word contents: 0x00500093 at 0x8, otherwise addr ^ 0x5A000013.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt    = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0000_0000;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic [31:0] full_intruc;
  logic [31:0] if_pc;
  logic        if_valid;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misalign;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  int          rsp_delay   = 1;
  int          cnt         = 0;
  logic [31:0] lat_addr    = 32'h0000_0000;
  logic [31:0] paddr       = 32'h0000_0000;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .full_intruc (full_intruc),
    .if_pc       (if_pc),
`ifdef FETCH_MISALIGN_EN
    .fetch_misalign (fetch_misalign),
`endif
    .if_valid    (if_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h0050_0093;
    else return a ^ 32'h5A00_0013;
  endfunction

  // Memory responder: outputs change on the falling edge only.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (imem_gnt) begin
      paddr = lat_addr;
      cnt   = rsp_delay;
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
      end
    end
    imem_gnt = imem_req;
    lat_addr = imem_addr;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    id_ready    = 1'b1;

    // Reset state
    tick();
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", full_intruc, 32'h0000_0013);
    chk("rst_pc",    if_pc, 32'h0000_0000);
`ifdef FETCH_MISALIGN_EN
    chk("rst_mis",   {31'd0, fetch_misalign}, 32'd0);
`endif
    rst_n = 1'b1;

    // Sequential fetch 0x0, 0x4, 0x8
    tick();
    chk("first_req",  {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_0000);
    chk("first_empty", {31'd0, if_valid}, 32'd0);
    tick();
    chk("wait_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("w0_valid", {31'd0, if_valid}, 32'd1);
    chk("w0_data",  full_intruc, 32'h5A00_0013);
    chk("w0_pc",    if_pc, 32'h0000_0000);
    chk("addr4",    imem_addr, 32'h0000_0004);
    tick();
    chk("w0_drained", {31'd0, if_valid}, 32'd0);
    tick();
    chk("w4_data", full_intruc, 32'h5A00_0017);
    chk("w4_pc",   if_pc, 32'h0000_0004);
    chk("addr8",   imem_addr, 32'h0000_0008);
    tick();
    chk("w4_drained", {31'd0, if_valid}, 32'd0);
    id_ready = 1'b0;

    // Back-pressure: word at 0x8 held for 5 cycles, skid fills with 0xC
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_instr", full_intruc, 32'h0050_0093);
      chk("stall_pc",    if_pc, 32'h0000_0008);
      if (i >= 1) chk("stall_noreq", {31'd0, imem_req}, 32'd0);
    end
    id_ready = 1'b1;
    tick();
    chk("skid_data", full_intruc, 32'h5A00_001F);
    chk("skid_pc",   if_pc, 32'h0000_000C);
    chk("addr10",    imem_addr, 32'h0000_0010);
    rsp_delay = 3;

    // Redirect while waiting on 0x10; stale response arrives later
    tick();
    chk("wait10_noreq", {31'd0, imem_req}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect  = 1'b0;
    rsp_delay = 1;
    chk("rd1_valid", {31'd0, if_valid}, 32'd0);
    chk("rd1_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("rd1_still_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("rd1_req",  {31'd0, imem_req}, 32'd1);
    chk("rd1_addr", imem_addr, 32'h0000_0100);
    chk("rd1_stale_dropped", {31'd0, if_valid}, 32'd0);
    tick();
    chk("rd1_wait_empty", {31'd0, if_valid}, 32'd0);
    tick();
    chk("w100_data", full_intruc, 32'h5A00_0113);
    chk("w100_pc",   if_pc, 32'h0000_0100);
    chk("addr104",   imem_addr, 32'h0000_0104);
    id_ready = 1'b0;

    // Redirect coincident with rvalid and id_ready
    tick();
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    chk("rd2_valid", {31'd0, if_valid}, 32'd0);
    chk("rd2_instr", full_intruc, 32'h0000_0013);
    chk("rd2_req",   {31'd0, imem_req}, 32'd1);
    chk("rd2_addr",  imem_addr, 32'h0000_0200);
    tick();
    tick();
    chk("w200_data", full_intruc, 32'h5A00_0213);
    chk("w200_pc",   if_pc, 32'h0000_0200);

    // Redirect in a granted ISSUE cycle, target at top of address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("rd3_noreq", {31'd0, imem_req}, 32'd0);
    chk("rd3_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("rd3_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("wtop_data", full_intruc, 32'hA5FF_FFEF);
    chk("wtop_pc",   if_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

`ifdef FETCH_MISALIGN_EN
    // Misaligned target traps and stalls until the next redirect
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0202;
    id_ready    = 1'b0;
    tick();
    redirect = 1'b0;
    chk("mis_flag",  {31'd0, fetch_misalign}, 32'd1);
    chk("mis_pc",    if_pc, 32'h0000_0202);
    chk("mis_instr", full_intruc, 32'h0000_0013);
    chk("mis_valid", {31'd0, if_valid}, 32'd1);
    chk("mis_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("mis_hold_flag",  {31'd0, fetch_misalign}, 32'd1);
    chk("mis_hold_noreq", {31'd0, imem_req}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    id_ready    = 1'b1;
    tick();
    redirect = 1'b0;
    chk("mis_clr",   {31'd0, fetch_misalign}, 32'd0);
    chk("mis_empty", {31'd0, if_valid}, 32'd0);
    chk("mis_req",   {31'd0, imem_req}, 32'd1);
    chk("mis_addr",  imem_addr, 32'h0000_0300);
    tick();
    tick();
`else
    // Misaligned target: low bits masked
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0303;
    tick();
    redirect = 1'b0;
    chk("mask_noreq", {31'd0, imem_req}, 32'd0);
    chk("mask_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("mask_addr", imem_addr, 32'h0000_0300);
    tick();
    tick();
`endif
    chk("w300_data", full_intruc, 32'h5A00_0313);
    chk("w300_pc",   if_pc, 32'h0000_0300);

    // Reset mid-transaction; late response must be ignored
    begin
      int n = 0;
      while (!imem_req && n < 20) begin
        tick();
        n++;
      end
      chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    end
    rsp_delay = 2;
    tick();
    chk("pre_rst_wait", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst2_req",   {31'd0, imem_req}, 32'd0);
    chk("rst2_valid", {31'd0, if_valid}, 32'd0);
    chk("rst2_instr", full_intruc, 32'h0000_0013);
    chk("rst2_pc",    if_pc, 32'h0000_0000);
    tick();
    rst_n = 1'b1;
    tick();
    rsp_delay = 1;
    chk("rst2_req1",  {31'd0, imem_req}, 32'd1);
    chk("rst2_addr",  imem_addr, 32'h0000_0000);
    chk("late_ignored", {31'd0, if_valid}, 32'd0);
    tick();
    chk("rst2_wait_empty", {31'd0, if_valid}, 32'd0);
    tick();
    chk("rst2_w0_valid", {31'd0, if_valid}, 32'd1);
    chk("rst2_w0_pc",    if_pc, 32'h0000_0000);
    chk("rst2_w0_data",  full_intruc, 32'h5A00_0013);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
